// File: rtl/body_temp_pkg.sv
// Shared types and constants for the body-temperature channel.
// Holds the controller state enum, datapath widths, the raw sensor word
// layout and the fraction-to-hundredths weight table.
package body_temp_pkg;

  localparam int unsigned RAW_W  = 15;
  localparam int unsigned VAL_W  = 8;
  localparam int unsigned BCD_W  = 4;
  localparam int unsigned INT_W  = 7;
  localparam int unsigned FRAC_N = 7;

  // Hundredths contributed by raw[7] down to raw[1].
  localparam logic [VAL_W-1:0] FRAC_WEIGHT [FRAC_N] =
    '{8'd50, 8'd25, 8'd12, 8'd6, 8'd3, 8'd2, 8'd1};

  // Raw sensor word: [14:8] integer degrees, [7:1] binary fraction, [0] unused.
  typedef struct packed {
    logic [INT_W-1:0]  int_part;
    logic [FRAC_N-1:0] frac;
    logic              lsb;
  } raw_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_AVG,
    ST_CONV_INT,
    ST_CONV_DEC,
    ST_DONE
  } state_e;

  // Weighted sum of the fraction bits; tops out at 99.
  function automatic logic [VAL_W-1:0] frac_to_dec(input logic [FRAC_N-1:0] frac);
    logic [VAL_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < FRAC_N; i++) begin
      if (frac[FRAC_N-1-i]) acc = acc + FRAC_WEIGHT[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/body_temp_ctrl_if.sv
// Sensor-reader handshake bundle.
//   rd_req  : level read request from the controller
//   rd_ack  : one-cycle data-valid from the reader
//   rd_data : raw 15-bit sensor word, valid with rd_ack
// master = controller side, slave = reader side.
interface body_temp_ctrl_if;
  import body_temp_pkg::*;

  logic rd_req;
  logic rd_ack;
  raw_t rd_data;

  modport master (output rd_req, input rd_ack, input rd_data);
  modport slave  (input rd_req, output rd_ack, output rd_data);
endinterface

// File: rtl/bcd_shift_conv.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble).
//   clk, rst  : clock, synchronous active-high reset
//   load, din : start a conversion of din
//   done_c    : high during the 8th shift cycle; digits valid alongside it
//   hun_c/ten_c/one_c : BCD digits after the current shift step
module bcd_shift_conv import body_temp_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [VAL_W-1:0] din,
  output logic             done_c,
  output logic [BCD_W-1:0] hun_c,
  output logic [BCD_W-1:0] ten_c,
  output logic [BCD_W-1:0] one_c
);

  localparam int unsigned SH_W  = 3*BCD_W + VAL_W;
  localparam int unsigned CNT_W = $clog2(VAL_W);

  logic [SH_W-1:0]  sh_q;
  logic [SH_W-1:0]  adj_c;
  logic [SH_W-1:0]  nxt_c;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  // One dabble step: add 3 to every digit >= 5, then shift left.
  always_comb begin
    adj_c = sh_q;
    for (int unsigned d = 0; d < 3; d++) begin
      if (sh_q[VAL_W + d*BCD_W +: BCD_W] >= BCD_W'(5))
        adj_c[VAL_W + d*BCD_W +: BCD_W] = sh_q[VAL_W + d*BCD_W +: BCD_W] + BCD_W'(3);
    end
    nxt_c = adj_c << 1;
  end

  assign done_c = active_q && (cnt_q == CNT_W'(VAL_W-1));
  assign {hun_c, ten_c, one_c} = nxt_c[SH_W-1 -: 3*BCD_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      sh_q     <= {{(3*BCD_W){1'b0}}, din};
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      sh_q  <= nxt_c;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_c) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/body_temp_ctrl.sv
// Body-temperature sampling controller with sequential BCD conversion.
// Schedules periodic (en) or on-demand (start) sensor reads over the rd
// handshake, splits the raw word into integer/hundredths, converts both
// with one shared bcd_shift_conv and publishes results with a valid pulse.
//   clk, rst      : clock, synchronous active-high reset
//   en, start     : periodic sampling enable, immediate-sample request
//   rd            : sensor reader handshake (master side)
//   temp_int/dec  : binary integer degrees / hundredths
//   int_*/dec_*   : BCD digits
//   valid, busy, fever, timeout : status
// Optional macro BODY_TEMP_AVG_EN: 4-deep raw history averaged before conversion.
module body_temp_ctrl import body_temp_pkg::*; #(
  parameter int unsigned SAMPLE_DIV  = 50_000_000,
  parameter int unsigned ACK_TIMEOUT = 1_000_000,
  parameter int unsigned FEVER_INT   = 37,
  parameter int unsigned FEVER_DEC   = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                start,
  body_temp_ctrl_if.master    rd,
  output logic [VAL_W-1:0]    temp_int,
  output logic [VAL_W-1:0]    temp_dec,
  output logic [BCD_W-1:0]    int_hun,
  output logic [BCD_W-1:0]    int_ten,
  output logic [BCD_W-1:0]    int_one,
  output logic [BCD_W-1:0]    dec_ten,
  output logic [BCD_W-1:0]    dec_one,
  output logic                valid,
  output logic                busy,
  output logic                fever,
  output logic                timeout
);

  localparam int unsigned TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  state_e             state_q, state_d;
  logic               pending_q, pending_d;
  logic [TICK_W-1:0]  tick_q;
  logic               tick_c, trig_c;
  logic [WAIT_W-1:0]  wait_q;
  logic [INT_W-1:0]   raw_int_q;
  logic [FRAC_N-1:0]  raw_frac_q;
  logic [3*BCD_W-1:0] stage_int_q;
  logic               rd_req_q;
  logic               take_c, int_cap_c, publish_c, to_hit_c;
  logic               conv_load_c, conv_done_c;
  logic [VAL_W-1:0]   conv_din_c, dec_c;
  logic [BCD_W-1:0]   conv_hun_c, conv_ten_c, conv_one_c;
  logic               fever_c;
  logic               unused_bits;

  assign rd.rd_req = rd_req_q;
  assign dec_c     = frac_to_dec(raw_frac_q);
  assign fever_c   = (VAL_W'(raw_int_q) > VAL_W'(FEVER_INT)) ||
                     ((VAL_W'(raw_int_q) == VAL_W'(FEVER_INT)) && (dec_c >= VAL_W'(FEVER_DEC)));

`ifdef BODY_TEMP_AVG_EN
  raw_t             hist_q [4];
  logic             hist_vld_q;
  logic [RAW_W+1:0] sum_c;

  assign sum_c = {2'b00, hist_q[0]} + {2'b00, hist_q[1]} +
                 {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
  // sum>>2 drops two bits; its own lsb is the ignored raw bit.
  assign unused_bits = ^sum_c[2:0];

  // First capture after reset seeds every entry; later ones evict the oldest.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_vld_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) hist_q[i] <= '0;
    end else if (take_c) begin
      hist_vld_q <= 1'b1;
      hist_q[0]  <= rd.rd_data;
      for (int unsigned i = 1; i < 4; i++)
        hist_q[i] <= hist_vld_q ? hist_q[i-1] : rd.rd_data;
    end
  end
`else
  // Fraction lsb carries no weight.
  assign unused_bits = rd.rd_data.lsb;
`endif

  // Sample-period tick; held at reload while sampling is disabled.
  assign tick_c = en && (tick_q == '0);
  assign trig_c = tick_c || start;

  always_ff @(posedge clk) begin
    if (rst || !en || tick_c) tick_q <= TICK_W'(SAMPLE_DIV - 1);
    else                      tick_q <= tick_q - TICK_W'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    take_c      = 1'b0;
    int_cap_c   = 1'b0;
    publish_c   = 1'b0;
    to_hit_c    = 1'b0;
    conv_load_c = 1'b0;
    conv_din_c  = '0;
    if (trig_c && (state_q != ST_IDLE)) pending_d = 1'b1;
    case (state_q)
      ST_IDLE: if (trig_c) state_d = ST_REQ;
      ST_REQ: begin
        if (rd.rd_ack) begin
          take_c = 1'b1;
`ifdef BODY_TEMP_AVG_EN
          state_d = ST_AVG;
`else
          conv_load_c = 1'b1;
          conv_din_c  = VAL_W'(rd.rd_data.int_part);
          state_d     = ST_CONV_INT;
`endif
        end else if (wait_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
          to_hit_c = 1'b1;
          state_d  = ST_IDLE;
        end
      end
`ifdef BODY_TEMP_AVG_EN
      ST_AVG: begin
        conv_load_c = 1'b1;
        conv_din_c  = VAL_W'(sum_c[RAW_W+1 -: INT_W]);
        state_d     = ST_CONV_INT;
      end
`endif
      ST_CONV_INT: begin
        if (conv_done_c) begin
          int_cap_c   = 1'b1;
          conv_load_c = 1'b1;
          conv_din_c  = dec_c;
          state_d     = ST_CONV_DEC;
        end
      end
      ST_CONV_DEC: begin
        if (conv_done_c) begin
          publish_c = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (pending_d) begin
          pending_d = 1'b0;
          state_d   = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!en) pending_d = 1'b0;
  end

  // Registered outputs and datapath; results land on the edge into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_req_q    <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      fever       <= 1'b0;
      temp_int    <= '0;
      temp_dec    <= '0;
      int_hun     <= '0;
      int_ten     <= '0;
      int_one     <= '0;
      dec_ten     <= '0;
      dec_one     <= '0;
      wait_q      <= '0;
      raw_int_q   <= '0;
      raw_frac_q  <= '0;
      stage_int_q <= '0;
    end else begin
      rd_req_q <= (state_d == ST_REQ);
      busy     <= (state_d != ST_IDLE);
      valid    <= publish_c;
      wait_q   <= ((state_q == ST_REQ) && (state_d == ST_REQ)) ? wait_q + WAIT_W'(1) : '0;
      if (to_hit_c)    timeout <= 1'b1;
      else if (take_c) timeout <= 1'b0;
`ifdef BODY_TEMP_AVG_EN
      if (state_q == ST_AVG) begin
        raw_int_q  <= sum_c[RAW_W+1 -: INT_W];
        raw_frac_q <= sum_c[RAW_W+1-INT_W -: FRAC_N];
      end
`else
      if (take_c) begin
        raw_int_q  <= rd.rd_data.int_part;
        raw_frac_q <= rd.rd_data.frac;
      end
`endif
      if (int_cap_c) stage_int_q <= {conv_hun_c, conv_ten_c, conv_one_c};
      if (publish_c) begin
        temp_int                    <= VAL_W'(raw_int_q);
        temp_dec                    <= dec_c;
        {int_hun, int_ten, int_one} <= stage_int_q;
        dec_ten                     <= conv_ten_c;
        dec_one                     <= conv_one_c;
        fever                       <= fever_c;
      end
    end
  end

  bcd_shift_conv u_conv (
    .clk    (clk),
    .rst    (rst),
    .load   (conv_load_c),
    .din    (conv_din_c),
    .done_c (conv_done_c),
    .hun_c  (conv_hun_c),
    .ten_c  (conv_ten_c),
    .one_c  (conv_one_c)
  );

endmodule

// File: tb/tb_body_temp_ctrl.sv
// Self-checking bench for body_temp_ctrl with a behavioural result model.
module tb_body_temp_ctrl;

`ifdef BODY_TEMP_AVG_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic       clk = 1'b0;
  logic       rst, en, start;
  logic [7:0] temp_int, temp_dec;
  logic [3:0] int_hun, int_ten, int_one, dec_ten, dec_one;
  logic       valid, busy, fever, timeout;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int e_int, e_dec, e_h, e_t, e_o, e_dt, e_do, e_fev;
  logic [14:0] hist [$];

  body_temp_ctrl_if bus ();

  body_temp_ctrl #(
    .SAMPLE_DIV  (32),
    .ACK_TIMEOUT (16),
    .FEVER_INT   (37),
    .FEVER_DEC   (30)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .rd       (bus),
    .temp_int (temp_int),
    .temp_dec (temp_dec),
    .int_hun  (int_hun),
    .int_ten  (int_ten),
    .int_one  (int_one),
    .dec_ten  (dec_ten),
    .dec_one  (dec_one),
    .valid    (valid),
    .busy     (busy),
    .fever    (fever),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: integer part, weighted-fraction hundredths, decimal digits, threshold.
  task automatic set_expected(input logic [14:0] raw);
    int wt [7];
    wt = '{50, 25, 12, 6, 3, 2, 1};
    e_int = int'(raw[14:8]);
    e_dec = 0;
    for (int i = 0; i < 7; i++) if (raw[7-i]) e_dec += wt[i];
    e_h   = e_int / 100;
    e_t   = (e_int / 10) % 10;
    e_o   = e_int % 10;
    e_dt  = e_dec / 10;
    e_do  = e_dec % 10;
    e_fev = ((e_int * 100 + e_dec) >= 3730) ? 1 : 0;
  endtask

  task automatic clear_expected();
    e_int = 0; e_dec = 0; e_h = 0; e_t = 0; e_o = 0; e_dt = 0; e_do = 0; e_fev = 0;
  endtask

  // Raw word the design should convert for this capture.
  function automatic logic [14:0] model_capture(input logic [14:0] raw);
`ifdef BODY_TEMP_AVG_EN
    int unsigned s;
    s = 0;
    if (hist.size() == 0) begin
      repeat (4) hist.push_front(raw);
    end else begin
      hist.push_front(raw);
      void'(hist.pop_back());
    end
    foreach (hist[i]) s += 32'(hist[i]);
    return 15'(s >> 2);
`else
    return raw;
`endif
  endfunction

  function automatic bit outs_match();
    return (temp_int === 8'(e_int)) && (temp_dec === 8'(e_dec)) &&
           (int_hun === 4'(e_h)) && (int_ten === 4'(e_t)) && (int_one === 4'(e_o)) &&
           (dec_ten === 4'(e_dt)) && (dec_one === 4'(e_do)) && (fever === 1'(e_fev));
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, "_int"},   32'(temp_int), 32'(e_int));
    chk({tag, "_dec"},   32'(temp_dec), 32'(e_dec));
    chk({tag, "_hun"},   32'(int_hun),  32'(e_h));
    chk({tag, "_ten"},   32'(int_ten),  32'(e_t));
    chk({tag, "_one"},   32'(int_one),  32'(e_o));
    chk({tag, "_dten"},  32'(dec_ten),  32'(e_dt));
    chk({tag, "_done"},  32'(dec_one),  32'(e_do));
    chk({tag, "_fever"}, 32'(fever),    32'(e_fev));
  endtask

  task automatic trigger_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("req_rise", 32'(bus.rd_req), 1);
    chk("busy_rise", 32'(busy), 1);
  endtask

  // Acknowledge the pending read after dly cycles, then check latency, hold and results.
  task automatic serve(input logic [14:0] raw, input int dly, input int start_at, input bit more);
    int a;
    bit held;
    held = 1'b1;
    repeat (dly) step();
    chk("req_wait", 32'(bus.rd_req), 1);
    bus.rd_data = raw;
    bus.rd_ack  = 1'b1;
    a = cyc;
    step();
    bus.rd_ack  = 1'b0;
    bus.rd_data = 15'($urandom);
    chk("req_fall", 32'(bus.rd_req), 0);
    while (!valid && (cyc - a) < 40) begin
      if (!outs_match()) held = 1'b0;
      if ((cyc - a) == start_at) start = 1'b1;
      step();
      start = 1'b0;
    end
    chk("hold", 32'(held), 1);
    chk("latency", 32'(cyc - a), 32'(LAT));
    set_expected(model_capture(raw));
    check_outs("res");
    chk("timeout_clr", 32'(timeout), 0);
    step();
    chk("valid_lo", 32'(valid), 0);
    chk("busy_after", 32'(busy), 32'(more));
    chk("req_after", 32'(bus.rd_req), 32'(more));
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b1; en = 1'b0; start = 1'b0;
    bus.rd_ack = 1'b0; bus.rd_data = '0;
    clear_expected();
    step(); step();
    check_outs("rst");
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req", 32'(bus.rd_req), 0);
    chk("rst_timeout", 32'(timeout), 0);
    rst = 1'b0;
    step();

    // Directed reads.
    trigger_start();
    serve(15'h2480, 3, -1, 1'b0);
    chk("d1_int", 32'(temp_int), 36);
    chk("d1_dec", 32'(temp_dec), 50);
    chk("d1_digits", {16'h0, int_hun, int_ten, int_one, 4'h0}, 32'h0360);
    trigger_start();
    serve(15'h26C0, 0, -1, 1'b0);
    trigger_start();
    serve(15'h7FFF, 1, -1, 1'b0);

    // No acknowledge: request gives up, results hold.
    trigger_start();
    n = 0; seen = 1'b0;
    while (bus.rd_req && n < 40) begin
      if (valid) seen = 1'b1;
      n++;
      step();
    end
    chk("to_req_len", 32'(n), 16);
    chk("to_flag", 32'(timeout), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_novalid", 32'(seen), 0);
    check_outs("to_hold");
    trigger_start();
    serve(15'h2480, 2, -1, 1'b0);

    // Stray acknowledge while idle.
    bus.rd_data = 15'h7FFF;
    bus.rd_ack  = 1'b1;
    step();
    bus.rd_ack  = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      if (valid || busy) seen = 1'b1;
      step();
    end
    chk("stray_ack", 32'(seen), 0);
    check_outs("stray_hold");

    // Automatic sampling period.
    en = 1'b1;
    n = 0;
    while (!bus.rd_req && n < 100) begin
      step();
      n++;
    end
    chk("tick_period", 32'(n), 32);
    en = 1'b0;
    serve(15'h2510, 0, -1, 1'b0);

    // start during CONV_INT queues exactly one more read straight after DONE.
    en = 1'b1;
    trigger_start();
    serve(15'h26C0, 2, 3, 1'b1);
    en = 1'b0;
    serve(15'h2480, 1, -1, 1'b0);

    // Reset during CONV_DEC aborts everything.
    trigger_start();
    bus.rd_data = 15'h7FFF;
    bus.rd_ack  = 1'b1;
    step();
    bus.rd_ack  = 1'b0;
    repeat (11) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    hist.delete();
    clear_expected();
    check_outs("midrst");
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_req", 32'(bus.rd_req), 0);
    repeat (3) begin
      if (valid) seen = 1'b1;
      step();
    end
    chk("midrst_novalid", 32'(valid), 0);
    trigger_start();
    serve(15'h2480, 0, -1, 1'b0);

    // Random raw words and acknowledge delays.
    for (int k = 0; k < 8; k++) begin
      trigger_start();
      serve(15'($urandom_range(0, 32767)), int'($urandom_range(0, 4)), -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
